// File: rtl/ss_symbol_decoder.sv
// Stochastic-symbol window decoder: sums 2^LOG2_WIN accepted 3-bit symbols into a binary result.
// Optional build macro SS_DECODER_ERR_EN saturates illegal symbols (5..7) to 4 and flags err.
module ss_symbol_decoder #(
  parameter int unsigned LOG2_WIN = 8,
  parameter int unsigned RW       = LOG2_WIN + 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    sym_ss,
  input  logic          sym_valid,
  output logic [RW-1:0] res_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          ovf,
  output logic          err
);

  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [RW-1:0]       acc_q, acc_d;
  logic [RW-1:0]       res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;
  logic                ovf_q, ovf_d;

  logic          acc_en;
  logic          win_last;
  logic          drain;
  logic [2:0]    sym_val;
  logic [RW-1:0] sum;

  assign acc_en   = en & sym_valid;
  assign win_last = &cnt_q;
  assign drain    = res_valid_q & res_ready;

`ifdef SS_DECODER_ERR_EN
  logic sym_illegal;
  logic err_q, err_d;

  assign sym_illegal = (sym_ss > 3'd4);
  assign sym_val     = sym_illegal ? 3'd4 : sym_ss;
  assign err_d       = err_q | (acc_en & sym_illegal);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign sym_val = sym_ss;
  assign err     = 1'b0;
`endif

  assign sum = acc_q + {{(RW-3){1'b0}}, sym_val};

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q & ~res_ready;
    ovf_d       = ovf_q;
    if (!en) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (sym_valid) begin
      if (win_last) begin
        cnt_d = '0;
        acc_d = '0;
        // A slot frees up when the held result is being drained on this same edge.
        if (!res_valid_q || res_ready) begin
          res_data_d  = sum;
          res_valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + LOG2_WIN'(1);
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign ovf       = ovf_q;

`ifndef SYNTHESIS
  res_hold_a: assert property (@(posedge clk) disable iff (!rst)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_data)));
`endif

endmodule

// File: tb/tb_ss_symbol_decoder.sv
// Scoreboard bench for ss_symbol_decoder with N=4: stimulus pushes expected sums, a monitor
// pops and compares on every output transfer.
module tb_ss_symbol_decoder;
  localparam int unsigned LOG2_WIN = 2;
  localparam int unsigned RW       = LOG2_WIN + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    sym_ss;
  logic          sym_valid;
  logic [RW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          ovf;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  ss_symbol_decoder #(.LOG2_WIN(LOG2_WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sym_ss    (sym_ss),
    .sym_valid (sym_valid),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid & ready hold here.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(res_data), -1);
      end else begin
        chk("res_data", int'(res_data), exp_q.pop_front());
      end
    end
  end

  task automatic send(input int s);
    sym_ss    = 3'(s);
    sym_valid = 1'b1;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    sym_ss    = 3'd0;
    sym_valid = 1'b0;
    res_ready = 1'b0;
    #2;
    chk("reset_valid", int'(res_valid), 0);
    chk("reset_data", int'(res_data), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_err", int'(err), 0);
    idle(2);
    rst = 1'b1;

    // Full-rate window of 4s.
    en = 1'b1;
    res_ready = 1'b1;
    exp_q.push_back(16);
    for (int i = 0; i < 4; i++) send(4);
    chk("s1_valid_on", int'(res_valid), 1);
    idle(1);
    chk("s1_valid_one_cycle", int'(res_valid), 0);
    chk("s1_ovf", int'(ovf), 0);

    // Gap in sym_valid stretches the window.
    exp_q.push_back(6);
    send(1);
    send(2);
    idle(2);
    chk("s2_no_early_valid", int'(res_valid), 0);
    send(3);
    send(0);
    chk("s2_valid_on", int'(res_valid), 1);
    idle(1);

    // Back-pressure: second window dropped.
    res_ready = 1'b0;
    exp_q.push_back(8);
    for (int i = 0; i < 4; i++) send(2);
    chk("s3_first_data", int'(res_data), 8);
    for (int i = 0; i < 4; i++) send(2);
    chk("s3_held_data", int'(res_data), 8);
    chk("s3_ovf", int'(ovf), 1);
    res_ready = 1'b1;
    idle(1);
    chk("s3_drained", int'(res_valid), 0);

    // Asynchronous reset with a held result and a partial window.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2);
    send(1);
    send(1);
    rst = 1'b0;
    #2;
    chk("rst_async_valid", int'(res_valid), 0);
    chk("rst_async_data", int'(res_data), 0);
    chk("rst_async_ovf", int'(ovf), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    res_ready = 1'b1;
    exp_q.push_back(10);
    send(1);
    send(2);
    send(3);
    send(4);
    idle(1);

    // Drain coincides with completion of the next window.
    res_ready = 1'b0;
    exp_q.push_back(4);
    exp_q.push_back(12);
    for (int i = 0; i < 4; i++) send(1);
    for (int i = 0; i < 3; i++) send(3);
    chk("s4_held", int'(res_data), 4);
    res_ready = 1'b1;
    send(3);
    chk("s4_valid_stays", int'(res_valid), 1);
    chk("s4_new_data", int'(res_data), 12);
    idle(1);
    chk("s4_drained", int'(res_valid), 0);
    chk("s4_ovf", int'(ovf), 0);

    // Illegal symbols.
`ifdef SS_DECODER_ERR_EN
    exp_q.push_back(8);
`else
    exp_q.push_back(14);
`endif
    send(7);
    send(7);
    send(0);
    send(0);
    idle(1);
`ifdef SS_DECODER_ERR_EN
    chk("s5_err", int'(err), 1);
`else
    chk("s5_err", int'(err), 0);
`endif

    // Dropping en discards the partial window.
    exp_q.push_back(4);
    send(4);
    send(4);
    en = 1'b0;
    idle(1);
    en = 1'b1;
    for (int i = 0; i < 4; i++) send(1);
    idle(2);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
